// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing HI/LO; all 32-bit arithmetic goes through the external ALU.
// Latency: 33 cycles start->done for unsigned ops, +1 per operand negate and per sign fixup; start ignored while busy.
module mult_div_sequencer #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [1:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  input  logic        alu_zero
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [4:0] LAST    = 5'(ITERS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FX_LO, S_FX_HI, S_FX_HI1, S_FX_Q, S_FX_R, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, a_nxt, b_q, b_nxt;
  logic [31:0] wh, wh_nxt, wl, wl_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic        is_div, is_div_nxt;
  logic        sa, sa_nxt, sb, sb_nxt;
  logic        dz, dz_nxt, lz, lz_nxt;
  logic        mc, acc;
  logic [31:0] mh, dsh;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      wh     <= '0;
      wl     <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      dz     <= 1'b0;
      lz     <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      wh     <= wh_nxt;
      wl     <= wl_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      cnt    <= cnt_nxt;
      is_div <= is_div_nxt;
      sa     <= sa_nxt;
      sb     <= sb_nxt;
      dz     <= dz_nxt;
      lz     <= lz_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = ALU_ADD;
    a_nxt      = a_q;
    b_nxt      = b_q;
    wh_nxt     = wh;
    wl_nxt     = wl;
    cnt_nxt    = cnt;
    is_div_nxt = is_div;
    sa_nxt     = sa;
    sb_nxt     = sb;
    dz_nxt     = dz;
    lz_nxt     = lz;
    mc         = 1'b0;
    mh         = '0;
    dsh        = '0;
    acc        = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          a_nxt      = rs;
          b_nxt      = rt;
          cnt_nxt    = '0;
          is_div_nxt = op[1];
          sa_nxt     = op[0] & rs[31];
          sb_nxt     = op[0] & rt[31];
          dz_nxt     = op[1] & (rt == 32'd0);
          wh_nxt     = '0;
          wl_nxt     = op[1] ? rs : rt;
          if (op[0] & rs[31])      state_nxt = S_NEG_A;
          else if (op[0] & rt[31]) state_nxt = S_NEG_B;
          else                     state_nxt = S_ITER;
        end
      end
      // Negated operands also replace the copy already seeded into the working pair.
      S_NEG_A: begin
        alu_b    = a_q;
        alu_ctrl = ALU_SUB;
        a_nxt    = alu_out;
        if (is_div) wl_nxt = alu_out;
        state_nxt = sb ? S_NEG_B : S_ITER;
      end
      S_NEG_B: begin
        alu_b    = b_q;
        alu_ctrl = ALU_SUB;
        b_nxt    = alu_out;
        if (!is_div) wl_nxt = alu_out;
        state_nxt = S_ITER;
      end
      S_ITER: begin
        if (!is_div) begin
          alu_a         = wh;
          alu_b         = a_q;
          {mc, mh}      = wl[0] ? {alu_carry, alu_out} : {1'b0, wh};
          wh_nxt        = {mc, mh[31:1]};
          wl_nxt        = {mh[0], wl[31:1]};
        end else begin
          // The bit shifted out of HI makes the partial remainder exceed any divisor.
          dsh      = {wh[30:0], wl[31]};
          alu_a    = dsh;
          alu_b    = b_q;
          alu_ctrl = ALU_SUB;
          acc      = wh[31] | ~alu_carry;
          wh_nxt   = acc ? alu_out : dsh;
          wl_nxt   = {wl[30:0], acc};
        end
        cnt_nxt = cnt + 5'd1;
        if (cnt == LAST) begin
          if (!is_div)      state_nxt = (sa ^ sb) ? S_FX_LO : S_DONE;
          else if (sa ^ sb) state_nxt = S_FX_Q;
          else              state_nxt = sa ? S_FX_R : S_DONE;
        end
      end
      S_FX_LO: begin
        alu_b     = wl;
        alu_ctrl  = ALU_SUB;
        wl_nxt    = alu_out;
        lz_nxt    = alu_zero;
        state_nxt = S_FX_HI;
      end
      S_FX_HI: begin
        alu_a     = wh;
        alu_b     = 32'hFFFF_FFFF;
        alu_ctrl  = ALU_XOR;
        wh_nxt    = alu_out;
        state_nxt = lz ? S_FX_HI1 : S_DONE;
      end
      S_FX_HI1: begin
        alu_a     = wh;
        alu_b     = 32'd1;
        wh_nxt    = alu_out;
        state_nxt = S_DONE;
      end
      S_FX_Q: begin
        alu_b     = wl;
        alu_ctrl  = ALU_SUB;
        wl_nxt    = alu_out;
        state_nxt = sa ? S_FX_R : S_DONE;
      end
      S_FX_R: begin
        alu_b     = wh;
        alu_ctrl  = ALU_SUB;
        wh_nxt    = alu_out;
        state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    hi_nxt = (state_nxt == S_DONE) ? wh_nxt : hi;
    lo_nxt = (state_nxt == S_DONE) ? wl_nxt : lo;
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign div_by_zero = done & dz;

endmodule
